// File: rtl/md_unit_pkg.sv
// md_unit shared types: MDOp encodings, latencies,
// FSM states and counter sizing.
package md_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

endpackage

// File: rtl/md_unit_if.sv
// EX-stage <-> md_unit bundle: operands, decode
// controls, busy and the HI/LO read-back.
interface md_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  MDOp;
  logic        MDSrc;
  logic        HIWrite;
  logic        LOWrite;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output A, B, MDOp,
    output MDSrc, HIWrite, LOWrite,
    input  busy, HI, LO
  );

  modport slave (
    input  A, B, MDOp,
    input  MDSrc, HIWrite, LOWrite,
    output busy, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO.
// Result is computed at start and held until busy drops.
module md_unit #(
  parameter int MULT_CYCLES = md_unit_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = md_unit_pkg::DIV_CYCLES
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave md
);
  import md_unit_pkg::*;

  localparam int CW =
    cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          done;
  logic          mt_ok;

  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_n, lo_n;
  logic [31:0] res_hi, res_lo;

  logic signed [63:0] sa, sb, sprod;
  logic [63:0] uprod;
  logic [31:0] a_mag, b_mag;
  logic [31:0] s_dvs, u_dvs;
  logic [31:0] sq, sr, uq, ur;

  assign md.busy = (state == RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

  assign mt_ok = (state == IDLE) && !md.MDSrc;

  always_comb begin
    sa     = {{32{md.A[31]}}, md.A};
    sb     = {{32{md.B[31]}}, md.B};
    sprod  = sa * sb;
    uprod  = {32'd0, md.A} * {32'd0, md.B};
    a_mag  = md.A[31] ? -md.A : md.A;
    b_mag  = md.B[31] ? -md.B : md.B;
    // Divisor forced to 1 on zero so no x leaks
    s_dvs  = (md.B == 32'd0) ? 32'd1 : b_mag;
    u_dvs  = (md.B == 32'd0) ? 32'd1 : md.B;
    sq     = a_mag / s_dvs;
    sr     = a_mag % s_dvs;
    uq     = md.A / u_dvs;
    ur     = md.A % u_dvs;
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (md.MDOp)
      MD_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      MD_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      MD_DIV: begin
        if (md.B != 32'd0) begin
          res_lo = (md.A[31] ^ md.B[31]) ? -sq : sq;
          res_hi = md.A[31] ? -sr : sr;
        end
      end
      MD_DIVU: begin
        if (md.B != 32'd0) begin
          res_lo = uq;
          res_hi = ur;
        end
      end
      default: begin
        res_hi = hi_q;
        res_lo = lo_q;
      end
    endcase
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (md.MDSrc) begin
          state_d = RUN;
          cnt_d   = md.MDOp[1] ? CW'(DIV_CYCLES)
                               : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (cnt == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      hi_n  <= '0;
      lo_n  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if ((state == IDLE) && md.MDSrc) begin
        hi_n <= res_hi;
        lo_n <= res_lo;
      end
      if (done) begin
        hi_q <= hi_n;
        lo_q <= lo_n;
      end else if (mt_ok) begin
        if (md.HIWrite) hi_q <= md.A;
        if (md.LOWrite) lo_q <= md.A;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic,
// mthi/mtlo, ignored requests and async reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  md_unit_if mdif ();

  md_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        hw,
    input logic        lw
  );
    @(negedge clk);
    mdif.MDOp    = op;
    mdif.A       = a;
    mdif.B       = b;
    mdif.MDSrc   = 1'b1;
    mdif.HIWrite = hw;
    mdif.LOWrite = lw;
    @(posedge clk);
    #1;
    mdif.MDSrc   = 1'b0;
    mdif.HIWrite = 1'b0;
    mdif.LOWrite = 1'b0;
    mdif.A       = ~a;
    mdif.B       = ~b;
    mdif.MDOp    = ~op;
  endtask

  task automatic wait_done(
    input int          n,
    input string       tag,
    input logic [31:0] old_hi,
    input logic [31:0] old_lo,
    input logic [31:0] exp_hi,
    input logic [31:0] exp_lo
  );
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, 32'(mdif.busy), 32'd1);
      chk({tag, "_hold_hi"}, mdif.HI, old_hi);
      chk({tag, "_hold_lo"}, mdif.LO, old_lo);
    end
    @(negedge clk);
    chk({tag, "_idle"}, 32'(mdif.busy), 32'd0);
    chk({tag, "_hi"}, mdif.HI, exp_hi);
    chk({tag, "_lo"}, mdif.LO, exp_lo);
  endtask

  task automatic mt(
    input logic [31:0] a,
    input logic        hw,
    input logic        lw
  );
    @(negedge clk);
    mdif.A       = a;
    mdif.HIWrite = hw;
    mdif.LOWrite = lw;
    @(posedge clk);
    #1;
    mdif.HIWrite = 1'b0;
    mdif.LOWrite = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    mdif.A       = '0;
    mdif.B       = '0;
    mdif.MDOp    = '0;
    mdif.MDSrc   = 1'b0;
    mdif.HIWrite = 1'b0;
    mdif.LOWrite = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(mdif.busy), 32'd0);
    chk("rst_hi", mdif.HI, 32'd0);
    chk("rst_lo", mdif.LO, 32'd0);
    reset = 1'b1;

    // -5 * 3 = -15
    issue(MD_MULT, 32'hFFFF_FFFB, 32'd3, 1'b0, 1'b0);
    wait_done(5, "mult", 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          1'b0, 1'b0);
    wait_done(5, "multu",
              32'hFFFF_FFFF, 32'hFFFF_FFF1,
              32'hFFFF_FFFE, 32'h0000_0001);

    // -7 / 2 = -3 rem -1
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_done(10, "div",
              32'hFFFF_FFFE, 32'h0000_0001,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);

    mt(32'h33, 1'b1, 1'b1);
    @(negedge clk);
    chk("mtboth_busy", 32'(mdif.busy), 32'd0);
    chk("mtboth_hi", mdif.HI, 32'h33);
    chk("mtboth_lo", mdif.LO, 32'h33);
    mt(32'h11, 1'b1, 1'b0);
    @(negedge clk);
    chk("mthi_hi", mdif.HI, 32'h11);
    chk("mthi_lo", mdif.LO, 32'h33);
    mt(32'h22, 1'b0, 1'b1);
    @(negedge clk);
    chk("mtlo_hi", mdif.HI, 32'h11);
    chk("mtlo_lo", mdif.LO, 32'h22);

    issue(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_done(10, "divz", 32'h11, 32'h22,
              32'h11, 32'h22);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          1'b0, 1'b0);
    wait_done(10, "dovf", 32'h11, 32'h22,
              32'd0, 32'h8000_0000);

    // start wins over mthi/mtlo raised alongside it
    issue(MD_MULT, 32'd4, 32'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("ign_busy", 32'(mdif.busy), 32'd1);
    mdif.MDSrc   = 1'b1;
    mdif.MDOp    = MD_DIVU;
    mdif.A       = 32'hDEAD;
    mdif.B       = 32'd1;
    mdif.HIWrite = 1'b1;
    @(posedge clk);
    #1;
    mdif.MDSrc   = 1'b0;
    mdif.HIWrite = 1'b0;
    wait_done(4, "ign", 32'd0, 32'h8000_0000,
              32'd0, 32'd20);
    mt(32'hBEEF, 1'b0, 1'b1);
    @(negedge clk);
    chk("beef_busy", 32'(mdif.busy), 32'd0);
    chk("beef_hi", mdif.HI, 32'd0);
    chk("beef_lo", mdif.LO, 32'hBEEF);

    issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(mdif.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(mdif.busy), 32'd0);
    chk("arst_hi", mdif.HI, 32'd0);
    chk("arst_lo", mdif.LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(MD_MULT, 32'd2, 32'd3, 1'b0, 1'b0);
    wait_done(5, "post", 32'd0, 32'd0,
              32'd0, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers in the EX stage.
- Consumes the EX-stage decode outputs MDOp, MDSrc, HIWrite and LOWrite, plus forwarded rs/rt operands.
- Feeds HI/LO back to the EX result mux, selected by the mfhi/mflo path.
- Exposes busy so the hazard unit can stall later md-class instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (min 1).
- DIV_CYCLES, 10, cycles busy is held for div/divu (min 1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- MDOp  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- MDSrc  in  1  start; operation issues when MDSrc=1 and busy=0.
- HIWrite  in  1  mthi request: HI<=A when MDSrc=0 and busy=0.
- LOWrite  in  1  mtlo request: LO<=A when MDSrc=0 and busy=0.
- busy  out  1  high while an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, pending result discarded. Applies immediately, including mid-operation.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE, start sampled at edge T (MDSrc=1):
  - latch the result of MDOp on A,B into internal hi_n/lo_n;
  - load counter with MULT_CYCLES (MDOp[1]=0) or DIV_CYCLES (MDOp[1]=1);
  - go to RUN.
- busy is high for exactly N cycles after edge T. At edge T+N: HI<=hi_n, LO<=lo_n, busy<=0, go to IDLE.
- HI/LO keep their old values throughout RUN; the new values are visible only after busy falls.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 to 64; HI=[63:32], LO=[31:0].
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (B=0, div or divu): unit still goes busy for DIV_CYCLES; HI/LO unchanged at completion.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0; no trap.
- MDSrc=1 while busy: ignored. The hazard unit guarantees stall; no queueing.
- HIWrite/LOWrite asserted together with MDSrc=1 (decode raises them for mult/div): ignored, start wins.
- HIWrite/LOWrite while busy: ignored.
- mthi/mtlo in IDLE: register updated at the next edge; busy stays 0.
- HIWrite and LOWrite both high in IDLE: both written from A.
- A/B/MDOp may change after the start edge without affecting the in-flight result.
- No combinational path from inputs to busy/HI/LO; all outputs are registered.

Decomposition:
- Shared package holds:
  - MDOp encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - default latencies MULT_CYCLES=5, DIV_CYCLES=10;
  - counter width, derived as clog2 of the maximum latency plus 1.
- Single module, no sub-module. The result compute is one combinational block selected by MDOp, registered at start. An iterative divider may later replace it behind the same timing contract.

Test Plan:
- mult A=0xFFFFFFFB(-5), B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO unchanged while busy.
- div A=0xFFFFFFF9(-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy 10 cycles; then HI=0x11, LO=0x22.
- During a mult, pulse MDSrc=1 (divu) and HIWrite=1 with A=0xDEAD -> both ignored, mult result lands at cycle 5. Next cycle mtlo A=0xBEEF -> LO=0xBEEF, busy stays 0.
- Start div, drive reset=0 asynchronously at cycle 4 (mid-cycle) -> busy, HI, LO all 0 immediately. Release reset and issue mult 2*3 -> LO=6 after 5 cycles.
